// File: rtl/re_cram_arbiter.sv
// ============================================================================
// Module   : re_cram_arbiter
// Brief    : Round-robin burst arbiter sharing one CRAM write port among
//            NUM_REQ requesters; one whole burst per grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module re_cram_arbiter #(
    parameter int NUM_REQ      = 5,
    parameter int WIDTH_DATA   = 32,
    parameter int WIDTH_LENGTH = 10,
    parameter int WIDTH_ID     = 3
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              I_Req,
    input  logic [NUM_REQ*WIDTH_LENGTH-1:0] I_Len,
    input  logic [NUM_REQ-1:0]              I_Valid,
    input  logic [NUM_REQ*WIDTH_DATA-1:0]   I_Data,
    output logic [NUM_REQ-1:0]              O_Nack,
    output logic [NUM_REQ-1:0]              O_Grant,
    output logic [WIDTH_ID-1:0]             O_GrantID,
    output logic                            O_Valid,
    output logic [WIDTH_DATA-1:0]           O_Data,
    output logic                            O_Last,
    input  logic                            I_Nack,
    output logic                            O_Busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARB     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic [WIDTH_ID-1:0]     grant_id_q, grant_id_d;
    logic [WIDTH_ID-1:0]     last_id_q, last_id_d;
    logic [WIDTH_LENGTH-1:0] rem_q, rem_d;

    logic [WIDTH_DATA-1:0]   w_data [NUM_REQ];
    logic [WIDTH_LENGTH-1:0] w_len  [NUM_REQ];

    logic                    w_hi_found;
    logic [WIDTH_ID-1:0]     w_hi_id;
    logic [WIDTH_ID-1:0]     w_lo_id;
    logic [WIDTH_ID-1:0]     w_win_id;
    logic [WIDTH_LENGTH-1:0] w_win_len;
    logic [WIDTH_DATA-1:0]   w_sel_data;
    logic                    w_sel_valid;
    logic                    w_xfer;
    logic                    w_beat;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_data[g] = I_Data[g*WIDTH_DATA +: WIDTH_DATA];
            assign w_len[g]  = I_Len[g*WIDTH_LENGTH +: WIDTH_LENGTH];
        end
    endgenerate

    // Round-robin: lowest requester above last_id wins, else wrap to lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_id    = '0;
        w_lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (I_Req[i]) begin
                w_lo_id = WIDTH_ID'(i);
                if (i > int'(last_id_q)) begin
                    w_hi_found = 1'b1;
                    w_hi_id    = WIDTH_ID'(i);
                end
            end
        end
        w_win_id = w_hi_found ? w_hi_id : w_lo_id;
    end

    always_comb begin
        w_win_len   = '0;
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_id == WIDTH_ID'(i)) begin
                w_win_len = w_len[i];
            end
            if (grant_id_q == WIDTH_ID'(i)) begin
                w_sel_data  = w_data[i];
                w_sel_valid = I_Valid[i];
            end
        end
    end

    assign w_xfer    = (state_q == ST_XFER);
    assign O_Valid   = w_xfer & w_sel_valid;
    assign O_Data    = w_xfer ? w_sel_data : '0;
    assign w_beat    = O_Valid & ~I_Nack;
    assign O_Last    = O_Valid & (rem_q == WIDTH_LENGTH'(1));
    assign O_Nack    = ~(grant_q & {NUM_REQ{w_xfer}}) | {NUM_REQ{I_Nack}};
    assign O_Grant   = grant_q;
    assign O_GrantID = grant_id_q;
    assign O_Busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        rem_d      = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (|I_Req) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (|I_Req) begin
                    grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_id;
                    grant_id_d = w_win_id;
                    rem_d      = w_win_len;
                    state_d    = (w_win_len == '0) ? ST_RELEASE : ST_XFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (w_beat) begin
                    rem_d = rem_q - WIDTH_LENGTH'(1);
                    if (rem_q == WIDTH_LENGTH'(1)) begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_RELEASE: begin
                last_id_d = grant_id_q;
                grant_d   = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            last_id_q  <= WIDTH_ID'(NUM_REQ - 1);
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            rem_q      <= rem_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_re_cram_arbiter.sv
// ============================================================================
// Module   : tb_re_cram_arbiter
// Brief    : Scoreboard bench for re_cram_arbiter: grant order and beat data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_re_cram_arbiter;
    localparam int N  = 5;
    localparam int WD = 32;
    localparam int WL = 10;
    localparam int WI = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    I_Req = '0;
    logic [N*WL-1:0] I_Len = '0;
    logic [N-1:0]    I_Valid = '1;
    logic [N*WD-1:0] I_Data = '0;
    logic            I_Nack = 1'b0;
    logic [N-1:0]    O_Nack;
    logic [N-1:0]    O_Grant;
    logic [WI-1:0]   O_GrantID;
    logic            O_Valid;
    logic [WD-1:0]   O_Data;
    logic            O_Last;
    logic            O_Busy;

    re_cram_arbiter #(
        .NUM_REQ(N), .WIDTH_DATA(WD), .WIDTH_LENGTH(WL), .WIDTH_ID(WI)
    ) dut (
        .clock(clock), .reset(reset), .I_Req(I_Req), .I_Len(I_Len),
        .I_Valid(I_Valid), .I_Data(I_Data), .O_Nack(O_Nack), .O_Grant(O_Grant),
        .O_GrantID(O_GrantID), .O_Valid(O_Valid), .O_Data(O_Data),
        .O_Last(O_Last), .I_Nack(I_Nack), .O_Busy(O_Busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [WI-1:0] id;
        logic [WD-1:0] data;
        logic          last;
    } beat_t;

    beat_t dq[$];
    int    gq[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    req_total[N];
    int    gcount[N];
    int    acc[N];
    int    exp_seq[N];
    logic  gseen[N];
    logic [N-1:0] prev_grant = '0;
    int    beats_seen = 0;
    beat_t e;
    int    g;

    initial begin
        for (int i = 0; i < N; i++) begin
            req_total[i] = 0;
            exp_seq[i]   = 0;
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            gcount[i] = 0;
            gseen[i]  = 1'b0;
        end
    end

    initial begin
        for (int i = 0; i < N; i++) acc[i] = 0;
    end

    // Requester model: hold I_Req while more bursts are wanted than grants seen.
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (O_Grant[i] && !gseen[i]) gcount[i] = gcount[i] + 1;
            gseen[i] = O_Grant[i];
            I_Req[i] = (req_total[i] > gcount[i]);
        end
    end

    // Each requester presents its next word after the previous one was accepted.
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < N; i++) begin
            I_Data[i*WD +: WD] = {8'(i), 24'(acc[i])};
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_grant = '0;
        end else begin
            n_cmp++;
            if ((O_Nack | O_Grant) !== '1) begin
                n_err++;
                $display("FAIL nack_nongranted: O_Nack=%b O_Grant=%b required non-granted nack=1", O_Nack, O_Grant);
            end
            if (O_Grant !== '0 && prev_grant === '0) begin
                n_cmp++;
                if (gq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_grant: O_Grant=%b required none", O_Grant);
                end else begin
                    g = gq.pop_front();
                    if (O_GrantID !== WI'(g) || O_Grant !== ({{(N-1){1'b0}}, 1'b1} << g)) begin
                        n_err++;
                        $display("FAIL grant_order: id=%0d grant=%b required id=%0d", O_GrantID, O_Grant, g);
                    end
                end
            end
            prev_grant = O_Grant;
            if (O_Valid === 1'b1 && I_Nack === 1'b0) begin
                beats_seen++;
                n_cmp++;
                if (dq.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: id=%0d data=%h required no beat", O_GrantID, O_Data);
                end else begin
                    e = dq.pop_front();
                    if (O_GrantID !== e.id || O_Data !== e.data || O_Last !== e.last) begin
                        n_err++;
                        $display("FAIL beat_data: id=%0d data=%h last=%b required id=%0d data=%h last=%b",
                                 O_GrantID, O_Data, O_Last, e.id, e.data, e.last);
                    end
                end
                if (O_GrantID < WI'(N)) acc[O_GrantID] = acc[O_GrantID] + 1;
            end
        end
    end

    task automatic set_len(input int id, input int len);
        I_Len[id*WL +: WL] = WL'(len);
    endtask

    task automatic push_burst(input int id, input int len);
        gq.push_back(id);
        for (int k = 0; k < len; k++) begin
            dq.push_back('{id: WI'(id), data: {8'(id), 24'(exp_seq[id] + k)}, last: (k == len - 1)});
        end
        exp_seq[id] = exp_seq[id] + len;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clock);
            #3;
            if (dq.size() == 0 && gq.size() == 0 && !O_Busy && I_Req == '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_beats(input int target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            #2;
            if (beats_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        #2;
        n_cmp++;
        if (O_Grant !== '0 || O_GrantID !== '0 || O_Valid !== 1'b0 || O_Last !== 1'b0 ||
            O_Busy !== 1'b0 || O_Nack !== '1) begin
            n_err++;
            $display("FAIL reset_values: grant=%b id=%0d valid=%b last=%b busy=%b nack=%b required 0/0/0/0/0/11111",
                     O_Grant, O_GrantID, O_Valid, O_Last, O_Busy, O_Nack);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_single;
        bit ok;
        set_len(0, 4);
        push_burst(0, 4);
        @(posedge clock);
        #1 req_total[0]++;
        @(negedge clock);
        #2;
        n_cmp++;
        if (I_Req !== 5'b00001 || O_Busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_t0: req=%b busy=%b required 00001/0", I_Req, O_Busy);
        end
        @(negedge clock);
        #2;
        n_cmp++;
        if (O_Busy !== 1'b1 || O_Grant !== '0) begin
            n_err++;
            $display("FAIL single_t1_arb: busy=%b grant=%b required 1/00000", O_Busy, O_Grant);
        end
        @(negedge clock);
        #2;
        n_cmp++;
        if (O_Grant !== 5'b00001 || O_Valid !== 1'b1 || O_Last !== 1'b0) begin
            n_err++;
            $display("FAIL single_t2_grant: grant=%b valid=%b last=%b required 00001/1/0", O_Grant, O_Valid, O_Last);
        end
        repeat (3) @(negedge clock);
        #2;
        n_cmp++;
        if (O_Last !== 1'b1 || O_Valid !== 1'b1) begin
            n_err++;
            $display("FAIL single_t5_last: last=%b valid=%b required 1/1", O_Last, O_Valid);
        end
        @(negedge clock);
        #2;
        n_cmp++;
        if (O_Busy !== 1'b1 || O_Valid !== 1'b0 || O_Grant !== 5'b00001) begin
            n_err++;
            $display("FAIL single_t6_release: busy=%b valid=%b grant=%b required 1/0/00001", O_Busy, O_Valid, O_Grant);
        end
        @(negedge clock);
        #2;
        n_cmp++;
        if (O_Busy !== 1'b0 || O_Grant !== '0) begin
            n_err++;
            $display("FAIL single_t7_idle: busy=%b grant=%b required 0/00000", O_Busy, O_Grant);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL single_done: outstanding beats=%0d grants=%0d required 0/0", dq.size(), gq.size());
        end
    endtask

    task automatic test_zero_len;
        bit ok;
        int b0;
        b0 = beats_seen;
        set_len(1, 0);
        set_len(3, 2);
        push_burst(1, 0);
        push_burst(3, 2);
        @(posedge clock);
        #1;
        req_total[1]++;
        req_total[3]++;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            #2;
            if (O_Grant[1] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || O_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_pulse: seen=%b valid=%b required 1/0", ok, O_Valid);
        end
        @(negedge clock);
        #2;
        n_cmp++;
        if (O_Grant !== '0) begin
            n_err++;
            $display("FAIL zero_len_clear: grant=%b required 00000", O_Grant);
        end
        wait_done(ok);
        n_cmp++;
        if (!ok || beats_seen - b0 != 2) begin
            n_err++;
            $display("FAIL zero_len_done: done=%b beats=%0d required 1/2", ok, beats_seen - b0);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        int b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        b0 = beats_seen;
        for (int i = 0; i < N; i++) set_len(i, 2);
        for (int i = 0; i < N; i++) push_burst(i, 2);
        push_burst(0, 2);
        @(posedge clock);
        #1;
        req_total[0] += 2;
        for (int i = 1; i < N; i++) req_total[i]++;
        wait_done(ok);
        n_cmp++;
        if (!ok || beats_seen - b0 != 12) begin
            n_err++;
            $display("FAIL round_robin_done: done=%b beats=%0d required 1/12", ok, beats_seen - b0);
        end
    endtask

    task automatic test_nack;
        bit ok;
        int b0;
        logic [WD-1:0] want;
        b0 = beats_seen;
        set_len(2, 3);
        push_burst(2, 3);
        want = {8'd2, 24'(exp_seq[2] - 1)};
        @(posedge clock);
        #1 req_total[2]++;
        wait_beats(b0 + 2, ok);
        @(posedge clock);
        #1 I_Nack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            #2;
            n_cmp++;
            if (!ok || O_Valid !== 1'b1 || O_Data !== want || O_Last !== 1'b1 ||
                O_Nack[2] !== 1'b1 || O_Grant !== 5'b00100) begin
                n_err++;
                $display("FAIL nack_hold: valid=%b data=%h last=%b nack=%b grant=%b required 1/%h/1/1xx/00100",
                         O_Valid, O_Data, O_Last, O_Nack, O_Grant, want);
            end
        end
        @(posedge clock);
        #1 I_Nack = 1'b0;
        wait_done(ok);
        n_cmp++;
        if (!ok || beats_seen - b0 != 3) begin
            n_err++;
            $display("FAIL nack_done: done=%b beats=%0d required 1/3", ok, beats_seen - b0);
        end
    endtask

    task automatic test_valid_gap;
        bit ok;
        int b0;
        b0 = beats_seen;
        set_len(4, 3);
        push_burst(4, 3);
        @(posedge clock);
        #1 req_total[4]++;
        wait_beats(b0 + 1, ok);
        @(posedge clock);
        #1 I_Valid[4] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            #2;
            n_cmp++;
            if (!ok || O_Valid !== 1'b0 || O_Grant !== 5'b10000 || O_Busy !== 1'b1 || O_Last !== 1'b0) begin
                n_err++;
                $display("FAIL valid_gap_hold: valid=%b grant=%b busy=%b last=%b required 0/10000/1/0",
                         O_Valid, O_Grant, O_Busy, O_Last);
            end
        end
        @(posedge clock);
        #1 I_Valid = '1;
        wait_done(ok);
        n_cmp++;
        if (!ok || beats_seen - b0 != 3) begin
            n_err++;
            $display("FAIL valid_gap_done: done=%b beats=%0d required 1/3", ok, beats_seen - b0);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int b0;
        b0 = beats_seen;
        set_len(0, 8);
        push_burst(0, 8);
        @(posedge clock);
        #1 req_total[0]++;
        wait_beats(b0 + 2, ok);
        reset = 1'b1;
        @(posedge clock);
        #2;
        dq.delete();
        gq.delete();
        exp_seq[0] = exp_seq[0] - 6;
        n_cmp++;
        if (!ok || O_Grant !== '0 || O_GrantID !== '0 || O_Valid !== 1'b0 || O_Last !== 1'b0 ||
            O_Busy !== 1'b0 || O_Nack !== '1) begin
            n_err++;
            $display("FAIL reset_mid_values: grant=%b id=%0d valid=%b last=%b busy=%b nack=%b required 0/0/0/0/0/11111",
                     O_Grant, O_GrantID, O_Valid, O_Last, O_Busy, O_Nack);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        set_len(0, 1);
        set_len(1, 1);
        push_burst(0, 1);
        push_burst(1, 1);
        b0 = beats_seen;
        req_total[0]++;
        req_total[1]++;
        wait_done(ok);
        n_cmp++;
        if (!ok || beats_seen - b0 != 2) begin
            n_err++;
            $display("FAIL reset_mid_after: done=%b beats=%0d required 1/2", ok, beats_seen - b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_round_robin();
        test_nack();
        test_valid_gap();
        test_reset_mid();
        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
